exp_e: RTL
==========

# exp_e

Sequential shift-and-add natural exponential that consumes the Q16.16 results of the `log_e` stage and reconstructs the 16-bit integer operand. It sits directly downstream of `log_e` in the ALU datapath and closes the log/antilog round trip used by the multiply-by-log path and by the verification benches. Each conversion is iterative, one table step per clock, behind a valid/ready handshake on both sides.

## Interface
- No parameters. The step table is fixed by the `log_e` constant set.
- `clk`  input  1  sole clock, all state updates on the rising edge
- `rst`  input  1  reset, asynchronous, active-high
- `in_valid`  input  1  `in_data` is valid
- `in_ready`  output  1  block can accept an operand
- `in_data`  input  32  ln(value) as unsigned Q16.16, range 0..0x000B1721
- `out_valid`  output  1  `out_data` and `out_ovf` are valid
- `out_ready`  input  1  consumer accepts the result
- `out_data`  output  16  e^in_data, rounded to the nearest integer and saturated
- `out_ovf`  output  1  result was clamped to 0xFFFF

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Working registers:
  - `y` is 32-bit unsigned and holds the residual.
  - `x` is 33-bit unsigned, Q17.16, the accumulated product.
  - `step` is a 4-bit counter.
  - `sat` is a 1-bit flag.
- IDLE:
  - `in_ready` = 1.
  - On `in_valid`: y←in_data, x←0x0_0001_0000 (1.0), step←0, sat←(in_data > 0x000B1721). Go to RUN.
- RUN: one step per cycle, indexed by `step` 0..10.
  - Steps 0–3 (shift k = 8, 4, 2, 1; constant c = 0x58B91, 0x2C5C8, 0x162E4, 0x0B172): if y ≥ c, then y←y−c and x←x<<k.
  - Steps 4–10 (k = 1..7; constant c = 0x067CD, 0x03920, 0x01E27, 0x00F85, 0x007E1, 0x003F8, 0x001FE): if y ≥ c, then y←y−c and x←x+(x>>k).
  - Compares are unsigned. A subtraction is never taken when y < c, so y never wraps.
  - `x` is 33 bits wide so that x ≤ 2^15·2.37·2^16 never wraps. The 33-bit width is required.
  - Steps 6 and 7 use the mathematically correct constants: ln(1.125)=0x1E27 and ln(1.0625)=0x0F85.
  - After step 10: r = (x + 0x8000) >> 16.
    - out_data ← 0xFFFF if sat or r > 0xFFFF; otherwise r[15:0].
    - out_ovf ← sat | (r > 0xFFFF).
    - Go to DONE.
- DONE:
  - `out_valid` = 1. `out_data` and `out_ovf` are held stable.
  - On `out_ready`, go to IDLE.
  - There is no bypass: `in_ready` = 0 in DONE, and a new operand is accepted only from IDLE on a later cycle.
- in_data = 0 gives out_data = 1. This matches `log_e`, which maps both inputs 0 and 1 to 0.
- Saturated inputs still run all 11 steps, so latency is fixed.

## Timing
- Reset values: in_ready=0 while rst is asserted and 1 in IDLE after rst deasserts; out_valid=0, out_data=0x0000, out_ovf=0; FSM=IDLE, x=0, y=0, step=0, sat=0.
- Acceptance happens on edge E0, where in_valid && in_ready.
- Steps execute on edges E1..E11. The result is registered at E11, and out_valid is high from E11.
- Latency is therefore 11 cycles from acceptance to out_valid.
- Minimum turnaround is 13 cycles per operand: DONE→IDLE takes one edge, then the next acceptance.
- The output handshake completes on the edge where out_valid && out_ready.
  - out_valid drops after that edge.
  - out_data keeps its last value until the next result is registered.
- out_ready is ignored outside DONE. in_valid is ignored outside IDLE, and in_data is sampled only at acceptance.
- Asserting rst at any time, including mid-RUN or in DONE, immediately forces reset values. The in-flight operand is discarded and no partial result appears.

## Test plan
- in_data=0x00000000 → out_valid exactly 11 cycles after acceptance, out_data=0x0001, out_ovf=0.
- in_data=0x000A65AF (ln 32768) → out_data=0x8000, out_ovf=0.
- in_data=0x00010000 (ln e) → out_data=0x0003.
- in_data=0xFFFFFFFF → out_data=0xFFFF, out_ovf=1, same 11-cycle latency.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid.
  - Require out_data stable, in_ready=0 and new in_valid pulses ignored for that whole period.
  - Then pulse out_ready: in_ready=1 on the next cycle.
- Reset mid-RUN:
  - Assert rst at step 5. Require all outputs at reset values immediately, with no out_valid.
  - Send in_data=0x000A65AF after release: out_data=0x8000 with nominal latency.
- Round trip with `log_e` in the loop, for data in {1, 2, 100, 1000, 65535}: out_data within ±1% of the original data (±1 LSB for data ≤ 100).

Source files
------------

// File: rtl/exp_e.sv
// exp_e: sequential shift-and-add natural exponential (antilog) for the
// Q16.16 output of log_e. One table step per clock, 11 steps per operand,
// valid/ready handshakes on both sides.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   in_data valid
//   in_ready   operand can be accepted (IDLE only)
//   in_data    ln(value), unsigned Q16.16, legal range 0..0x000B1721
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_data   round(e^in_data), saturated to 0xFFFF
//   out_ovf    result was clamped
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// RUN   | stepping the ln table, one entry per cycle (step 0..10)
// DONE  | result held on out_data/out_ovf until out_ready

module exp_e (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [31:0] LN_MAX = 32'h000B_1721;
  localparam logic [32:0] X_ONE  = 33'h0_0001_0000;

  state_t      state_q, state_d;
  logic [31:0] y_q, y_d;
  logic [32:0] x_q, x_d;
  logic [3:0]  step_q, step_d;
  logic        sat_q, sat_d;
  logic        in_ready_q, in_ready_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_ovf_q, out_ovf_d;

  logic [31:0] c_step;
  logic [32:0] x_grow;
  logic        take;
  logic [32:0] x_run;
  logic [31:0] y_run;
  logic [17:0] r;
  logic        r_big;

  // ln table: steps 0..3 are powers of two (8,4,2,1 ln2), steps 4..10 are
  // ln(1 + 2^-k) for k = 1..7.
  always_comb begin
    c_step = 32'h0;
    case (step_q)
      4'd0:    c_step = 32'h0005_8B91;
      4'd1:    c_step = 32'h0002_C5C8;
      4'd2:    c_step = 32'h0001_62E4;
      4'd3:    c_step = 32'h0000_B172;
      4'd4:    c_step = 32'h0000_67CD;
      4'd5:    c_step = 32'h0000_3920;
      4'd6:    c_step = 32'h0000_1E27;
      4'd7:    c_step = 32'h0000_0F85;
      4'd8:    c_step = 32'h0000_07E1;
      4'd9:    c_step = 32'h0000_03F8;
      4'd10:   c_step = 32'h0000_01FE;
      default: c_step = 32'h0;
    endcase
  end

  always_comb begin
    x_grow = x_q;
    case (step_q)
      4'd0:    x_grow = x_q << 8;
      4'd1:    x_grow = x_q << 4;
      4'd2:    x_grow = x_q << 2;
      4'd3:    x_grow = x_q << 1;
      default: x_grow = x_q + (x_q >> (step_q - 4'd3));
    endcase
  end

  // Greedy: subtract only when the residual covers the constant, so y never wraps.
  // x stays below 2^33 even for saturated inputs, so the 33-bit width holds the product.
  always_comb begin
    take  = (y_q >= c_step);
    x_run = take ? x_grow : x_q;
    y_run = take ? (y_q - c_step) : y_q;
    r     = 18'(({1'b0, x_run} + 34'h0_0000_8000) >> 16);
    r_big = |r[17:16];
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    x_d         = x_q;
    step_d      = step_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          y_d     = in_data;
          x_d     = X_ONE;
          step_d  = 4'd0;
          sat_d   = (in_data > LN_MAX);
          state_d = RUN;
        end
      end
      RUN: begin
        y_d = y_run;
        x_d = x_run;
        if (step_q == 4'd10) begin
          out_data_d  = (sat_q || r_big) ? 16'hFFFF : r[15:0];
          out_ovf_d   = sat_q | r_big;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered so that in_ready stays low through reset and rises one
    // edge after release; DONE->IDLE raises it on the handshake edge.
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= 32'h0;
      x_q         <= 33'h0;
      step_q      <= 4'd0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'h0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      x_q         <= x_d;
      step_q      <= step_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule
